// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: resolves E0/F0 prefixes, skips the E1 Pause sequence,
// filters typematic repeats of held direction keys and tracks the held move direction.
// Define PS2_WASD_EN to let W/S/A/D also drive up/down/left/right.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int E1_SKIP        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_en,
    input  logic [7:0] key_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic [2:0] move,
    output logic       move_strobe
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int SK_W = (E1_SKIP > 1) ? $clog2(E1_SKIP + 1) : 1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic [SK_W-1:0] skip_cnt, skip_nxt;
    logic            timed, to_hit;
    logic            ev_fire, ev_make, ev_ext;

    logic            is_dir, own_held, commit, strobe_nxt;
    logic [1:0]      dir_idx;
    logic [2:0]      move_nxt;
    logic [3:0]      held_arrow, arrow_nxt, dir_mask, dir_after;
`ifdef PS2_WASD_EN
    logic            is_wasd;
    logic [3:0]      held_wasd, wasd_nxt;
`endif

    // Priority fallback when the current direction is released: up > down > left > right.
    function automatic logic [2:0] fallback(input logic [3:0] mask);
        if (mask[0])      return 3'd1;
        else if (mask[1]) return 3'd2;
        else if (mask[2]) return 3'd3;
        else if (mask[3]) return 3'd4;
        else              return 3'd0;
    endfunction

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        to_nxt    = '0;
        ev_fire   = 1'b0;
        ev_make   = 1'b0;
        ev_ext    = 1'b0;
        timed     = (state == EXT) || (state == BRK) || (state == EXT_BRK);
        to_hit    = timed && !key_en && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        if (timed && !key_en && !to_hit)
            to_nxt = to_cnt + TO_W'(1);

        case (state)
            IDLE: begin
                if (key_en) begin
                    case (key_data)
                        8'hE0: state_nxt = EXT;
                        8'hF0: state_nxt = BRK;
                        8'hE1: begin
                            state_nxt = SKIP;
                            skip_nxt  = SK_W'(E1_SKIP);
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: begin
                            ev_fire = 1'b1;
                            ev_make = 1'b1;
                        end
                    endcase
                end
            end
            EXT: begin
                if (key_en) begin
                    if (key_data == 8'hF0) begin
                        state_nxt = EXT_BRK;
                    end else if (key_data != 8'hE0) begin
                        ev_fire   = 1'b1;
                        ev_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            BRK, EXT_BRK: begin
                if (key_en) begin
                    ev_fire   = 1'b1;
                    ev_ext    = (state == EXT_BRK);
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                end
            end
            SKIP: begin
                if (key_en) begin
                    if (skip_cnt <= SK_W'(1)) begin
                        state_nxt = IDLE;
                        skip_nxt  = '0;
                    end else begin
                        skip_nxt = skip_cnt - SK_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Direction decode, repeat filter and held-mask / move update for the completed code.
    always_comb begin
        is_dir  = 1'b0;
        dir_idx = 2'd0;
        if (ev_ext) begin
            case (key_data)
                8'h75: begin is_dir = 1'b1; dir_idx = 2'd0; end
                8'h72: begin is_dir = 1'b1; dir_idx = 2'd1; end
                8'h6B: begin is_dir = 1'b1; dir_idx = 2'd2; end
                8'h74: begin is_dir = 1'b1; dir_idx = 2'd3; end
                default: ;
            endcase
        end
        arrow_nxt = held_arrow;
`ifdef PS2_WASD_EN
        is_wasd = 1'b0;
        if (!ev_ext) begin
            case (key_data)
                8'h1D: begin is_dir = 1'b1; is_wasd = 1'b1; dir_idx = 2'd0; end
                8'h1B: begin is_dir = 1'b1; is_wasd = 1'b1; dir_idx = 2'd1; end
                8'h1C: begin is_dir = 1'b1; is_wasd = 1'b1; dir_idx = 2'd2; end
                8'h23: begin is_dir = 1'b1; is_wasd = 1'b1; dir_idx = 2'd3; end
                default: ;
            endcase
        end
        wasd_nxt = held_wasd;
        own_held = is_wasd ? held_wasd[dir_idx] : held_arrow[dir_idx];
        dir_mask = held_arrow | held_wasd;
`else
        own_held = held_arrow[dir_idx];
        dir_mask = held_arrow;
`endif
        commit     = ev_fire && !(ev_make && is_dir && own_held);
        move_nxt   = move;
        strobe_nxt = 1'b0;
        dir_after  = dir_mask;
        if (commit && is_dir) begin
`ifdef PS2_WASD_EN
            if (is_wasd) wasd_nxt[dir_idx] = ev_make;
            else         arrow_nxt[dir_idx] = ev_make;
            dir_after = arrow_nxt | wasd_nxt;
`else
            arrow_nxt[dir_idx] = ev_make;
            dir_after = arrow_nxt;
`endif
            if (ev_make) begin
                move_nxt   = {1'b0, dir_idx} + 3'd1;
                strobe_nxt = !dir_mask[dir_idx];
            end else if ((move == {1'b0, dir_idx} + 3'd1) && !dir_after[dir_idx]) begin
                move_nxt = fallback(dir_after);
            end
        end
    end

    // Commit stage: all event outputs update together one cycle after the completing byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            skip_cnt    <= '0;
            held_arrow  <= '0;
`ifdef PS2_WASD_EN
            held_wasd   <= '0;
`endif
            keycode     <= '0;
            key_make    <= 1'b0;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            move        <= '0;
            move_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            to_cnt      <= to_nxt;
            skip_cnt    <= skip_nxt;
            held_arrow  <= arrow_nxt;
`ifdef PS2_WASD_EN
            held_wasd   <= wasd_nxt;
`endif
            key_valid   <= commit;
            move        <= move_nxt;
            move_strobe <= strobe_nxt;
            if (commit) begin
                keycode  <= key_data;
                key_make <= ev_make;
                key_ext  <= ev_ext;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus a random byte stream
// compared against a byte-level behavioural model of the decoder.
module tb_ps2_key_decoder;

    localparam int T   = 40;
    localparam int E1S = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_en = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, move_strobe;
    logic [2:0] move;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T), .E1_SKIP(E1S)) dut (
        .clk(clk), .reset(reset), .key_en(key_en), .key_data(key_data),
        .keycode(keycode), .key_make(key_make), .key_ext(key_ext),
        .key_valid(key_valid), .move(move), .move_strobe(move_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int idle_since = 0;
    int n_valid = 0;
    int n_strobe = 0;

    // Reference model state
    bit pend_ext, pend_brk;
    int skip_left;
    bit held [4];
    int exp_code, exp_make, exp_ext, exp_move, exp_valid, exp_strobe;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int dir_of(input logic [7:0] c, input bit ext);
        if (!ext) return -1;
        case (c)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        pend_ext = 0; pend_brk = 0; skip_left = 0;
        for (int i = 0; i < 4; i++) held[i] = 0;
        exp_code = 0; exp_make = 0; exp_ext = 0; exp_move = 0;
        exp_valid = 0; exp_strobe = 0;
    endtask

    task automatic model_event(input logic [7:0] c, input bit mk, input bit ext);
        int d;
        d = dir_of(c, ext);
        if (mk && d >= 0 && held[d]) return;
        exp_valid = 1;
        exp_code = c; exp_make = mk; exp_ext = ext;
        if (d >= 0) begin
            if (mk) begin
                held[d] = 1;
                exp_move = d + 1;
                exp_strobe = 1;
            end else begin
                held[d] = 0;
                if (exp_move == d + 1) begin
                    exp_move = 0;
                    for (int i = 3; i >= 0; i--) if (held[i]) exp_move = i + 1;
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int gap);
        exp_valid = 0; exp_strobe = 0;
        if ((pend_ext || pend_brk) && gap >= T) begin
            pend_ext = 0; pend_brk = 0;
        end
        if (skip_left > 0) begin
            skip_left--;
        end else if (pend_brk) begin
            model_event(b, 0, pend_ext);
            pend_ext = 0; pend_brk = 0;
        end else if (pend_ext) begin
            if (b == 8'hF0) pend_brk = 1;
            else if (b != 8'hE0) begin
                model_event(b, 1, 1);
                pend_ext = 0;
            end
        end else if (b == 8'hE0) pend_ext = 1;
        else if (b == 8'hF0) pend_brk = 1;
        else if (b == 8'hE1) skip_left = E1S;
        else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) model_event(b, 1, 0);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b, idle_since);
        idle_since = 0;
        key_data = b;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
        n_valid += int'(key_valid);
        n_strobe += int'(move_strobe);
        check("key_valid", key_valid, exp_valid);
        check("move_strobe", move_strobe, exp_strobe);
        check("keycode", keycode, exp_code);
        check("key_make", key_make, exp_make);
        check("key_ext", key_ext, exp_ext);
        check("move", move, exp_move);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_since++;
            check("quiet_pulses", {key_valid, move_strobe}, 0);
        end
    endtask

    task automatic press(input logic [7:0] c);
        send(8'hE0); send(c);
    endtask

    task automatic release_key(input logic [7:0] c);
        send(8'hE0); send(8'hF0); send(c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_keycode", keycode, 0);
        check("rst_make", key_make, 0);
        check("rst_ext", key_ext, 0);
        check("rst_valid", key_valid, 0);
        check("rst_move", move, 0);
        check("rst_strobe", move_strobe, 0);
        reset = 1'b0;
        model_clear();
        idle_since = 0;
    endtask

    initial begin
        model_clear();
        do_reset();

        // Up arrow make then break
        press(8'h75);
        check("tp_up_move", move, 1);
        check("tp_up_strobe", move_strobe, 1);
        check("tp_up_ext", key_ext, 1);
        release_key(8'h75);
        check("tp_upbrk_make", key_make, 0);
        check("tp_upbrk_move", move, 0);
        check("tp_upbrk_strobe", move_strobe, 0);

        // Typematic filtering on left, then right overrides and falls back
        n_valid = 0; n_strobe = 0;
        for (int i = 0; i < 3; i++) begin press(8'h6B); idle(1); end
        check("tp_rep_valid", n_valid, 1);
        check("tp_rep_strobe", n_strobe, 1);
        press(8'h74);
        check("tp_right_move", move, 4);
        release_key(8'h74);
        check("tp_right_brk_move", move, 3);
        release_key(8'h6B);
        check("tp_left_brk_move", move, 0);

        // Priority fallback
        press(8'h75); press(8'h72); press(8'h74);
        release_key(8'h74);
        check("tp_prio_up", move, 1);
        release_key(8'h75);
        check("tp_prio_down", move, 2);
        release_key(8'h72);
        check("tp_prio_none", move, 0);

        // Pause sequence is swallowed; up stays held across it
        press(8'h75);
        n_valid = 0;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("tp_pause_quiet", n_valid, 0);
        send(8'h1C);
        check("tp_1c_code", keycode, 8'h1C);
        check("tp_1c_ext", key_ext, 0);
        check("tp_1c_move", move, 1);
        release_key(8'h75);

        // Prefix timeout boundary
        send(8'hE0); idle(T); send(8'h75);
        check("tp_to_ext", key_ext, 0);
        check("tp_to_code", keycode, 8'h75);
        check("tp_to_move", move, 0);
        send(8'hE0); idle(T - 1); send(8'h75);
        check("tp_noto_ext", key_ext, 1);
        check("tp_noto_move", move, 1);
        release_key(8'h75);
        send(8'hF0); idle(T); send(8'h29);
        check("tp_brkto_make", key_make, 1);

        // Reset discards a pending break prefix; ack bytes are ignored
        send(8'hF0);
        do_reset();
        send(8'h29);
        check("tp_rst_code", keycode, 8'h29);
        check("tp_rst_make", key_make, 1);
        n_valid = 0;
        send(8'hAA); send(8'hFA);
        check("tp_ack_quiet", n_valid, 0);

        // Random byte stream
        for (int k = 0; k < 800; k++) begin
            logic [7:0] b;
            logic [7:0] pool [4];
            int r, g;
            r = $urandom_range(0, 99);
            if (r < 18)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 32) b = 8'hE1;
            else if (r < 60) begin
                pool[0] = 8'h75; pool[1] = 8'h72; pool[2] = 8'h6B; pool[3] = 8'h74;
                b = pool[$urandom_range(0, 3)];
            end else if (r < 70) begin
                pool[0] = 8'h1D; pool[1] = 8'h1B; pool[2] = 8'h1C; pool[3] = 8'h29;
                b = pool[$urandom_range(0, 3)];
            end else if (r < 78) begin
                pool[0] = 8'hAA; pool[1] = 8'hFA; pool[2] = 8'h00; pool[3] = 8'hFF;
                b = pool[$urandom_range(0, 3)];
            end else b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            if (r < 82)      g = $urandom_range(0, 2);
            else if (r < 90) g = T - 1;
            else if (r < 96) g = T;
            else             g = T + 3;
            idle(g);
            send(b);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
